load_store_unit: RTL and testbench

Sequential load/store unit that sits directly upstream of the 128-word, 32-bit data memory. It accepts byte, halfword and word load/store requests from the CPU and drives the memory's word address, write data, read and write strobes. It consumes the memory's registered read data. Sub-word stores are done as read-modify-write, and loads are sign- or zero-extended.

---
 rtl/load_store_unit.sv | 165 ++++++++++++++++
 tb/tb_load_store_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store unit in front of a 128x32 data memory; sub-word stores use read-modify-write.
// Optional LSU_MISALIGN_TRAP_EN: misaligned halfword/word requests complete with Err instead of being force-aligned.
module load_store_unit (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Req,
  input  logic        IsStore,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [8:0]  ByteAddr,
  input  logic [31:0] StoreData,
  output logic        Ready,
  output logic        Done,
  output logic        Err,
  output logic [31:0] LoadData,
  output logic [6:0]  MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] MemReadData
);

  // state | meaning
  // IDLE  | ready, waiting for Req
  // RD    | memory read strobe
  // CAP   | read data valid: extend for loads, merge for sub-word stores
  // WR    | memory write strobe
  // DONE  | completion pulse (Err for rejected requests)
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

  state_t      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [8:0]  addr_q, addr_d;
  logic [15:0] store_data_q, store_data_d;
  logic        err_q, err_d;
  logic [31:0] load_data_q, load_data_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        illegal;
  logic [8:0]  req_addr;
  logic [4:0]  byte_shamt;
  logic [4:0]  half_shamt;
  logic [31:0] byte_shifted;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;
  logic [31:0] merged;

  always_comb begin
    req_addr = ByteAddr;
`ifdef LSU_MISALIGN_TRAP_EN
    illegal = (Size == 2'b11) ||
              ((Size == 2'b01) && ByteAddr[0]) ||
              ((Size == 2'b10) && (ByteAddr[1:0] != 2'b00));
`else
    illegal = (Size == 2'b11);
    // without the trap, misaligned accesses drop the offset bits
    if (Size == 2'b01) req_addr[0] = 1'b0;
    if (Size == 2'b10) req_addr[1:0] = 2'b00;
`endif
  end

  always_comb begin
    byte_shamt   = {addr_q[1:0], 3'b000};
    half_shamt   = {addr_q[1], 4'b0000};
    byte_shifted = MemReadData >> byte_shamt;
    lane_byte    = byte_shifted[7:0];
    lane_half    = addr_q[1] ? MemReadData[31:16] : MemReadData[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{~unsigned_q & lane_byte[7]}}, lane_byte};
      2'b01:   load_ext = {{16{~unsigned_q & lane_half[15]}}, lane_half};
      default: load_ext = MemReadData;
    endcase
    if (size_q == 2'b00)
      merged = (MemReadData & ~(32'h0000_00FF << byte_shamt)) |
               ({24'h0, store_data_q[7:0]} << byte_shamt);
    else
      merged = (MemReadData & ~(32'h0000_FFFF << half_shamt)) |
               ({16'h0, store_data_q} << half_shamt);
  end

  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    addr_d       = addr_q;
    store_data_d = store_data_q;
    err_d        = err_q;
    load_data_d  = load_data_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (Req) begin
          is_store_d   = IsStore;
          size_d       = Size;
          unsigned_d   = Unsigned;
          addr_d       = req_addr;
          store_data_d = StoreData[15:0];
          err_d        = illegal;
          if (illegal) begin
            state_d = DONE;
          end else if (IsStore && (Size == 2'b10)) begin
            mem_wdata_d = StoreData;
            state_d     = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD:  state_d = CAP;
      CAP: begin
        if (is_store_q) begin
          mem_wdata_d = merged;
          state_d     = WR;
        end else begin
          load_data_d = load_ext;
          state_d     = DONE;
        end
      end
      WR:  state_d = DONE;
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= IDLE;
      is_store_q   <= 1'b0;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      addr_q       <= 9'h000;
      store_data_q <= 16'h0000;
      err_q        <= 1'b0;
      load_data_q  <= 32'h0;
      mem_wdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      addr_q       <= addr_d;
      store_data_q <= store_data_d;
      err_q        <= err_d;
      load_data_q  <= load_data_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign Ready        = (state_q == IDLE);
  assign MemRead      = (state_q == RD);
  assign MemWrite     = (state_q == WR);
  assign Done         = (state_q == DONE);
  assign Err          = (state_q == DONE) && err_q;
  assign LoadData     = load_data_q;
  assign MemAddress   = addr_q[8:2];
  assign MemWriteData = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a registered-read 128x32 memory model.
module tb_load_store_unit;
  logic        Clk, Rst_n, Req, IsStore, Unsigned;
  logic [1:0]  Size;
  logic [8:0]  ByteAddr;
  logic [31:0] StoreData;
  logic        Ready, Done, Err, MemRead, MemWrite;
  logic [31:0] LoadData, MemWriteData, MemReadData;
  logic [6:0]  MemAddress;

  logic [31:0] mem [0:127];
  logic        pre_we;
  logic [6:0]  pre_addr;
  logic [31:0] pre_data;

  int n_cmp = 0, n_fail = 0;
  int rd_cyc, wr_cyc, done_cyc, n_rd, n_wr, n_done, wr_evts;
  logic        err_seen;
  logic [31:0] wr_data;
  logic [6:0]  wr_addr;
  logic [31:0] exp_ld;

  load_store_unit dut (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .IsStore(IsStore), .Size(Size),
    .Unsigned(Unsigned), .ByteAddr(ByteAddr), .StoreData(StoreData),
    .Ready(Ready), .Done(Done), .Err(Err), .LoadData(LoadData),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemReadData(MemReadData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (MemWrite) mem[MemAddress] <= MemWriteData;
    else if (pre_we) mem[pre_addr] <= pre_data;
    if (MemRead) MemReadData <= mem[MemAddress];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [6:0] a, input logic [31:0] d);
    @(negedge Clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge Clk);
    pre_we = 1'b0;
  endtask

  // Issues one request and watches 8 cycles after the accepting edge.
  task automatic do_req(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [8:0] a, input logic [31:0] d, input bit pulse);
    @(negedge Clk);
    Req = 1'b1; IsStore = st; Size = sz; Unsigned = uns; ByteAddr = a; StoreData = d;
    @(posedge Clk);
    #1 Req = 1'b0;
    rd_cyc = 0; wr_cyc = 0; done_cyc = 0; n_rd = 0; n_wr = 0; n_done = 0;
    err_seen = 1'b0; wr_data = 32'h0; wr_addr = 7'h0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge Clk);
      if (MemRead) begin n_rd++; if (rd_cyc == 0) rd_cyc = n; end
      if (MemWrite) begin
        n_wr++;
        if (wr_cyc == 0) begin wr_cyc = n; wr_data = MemWriteData; wr_addr = MemAddress; end
      end
      if (Done) begin
        n_done++;
        if (done_cyc == 0) begin done_cyc = n; err_seen = Err; end
      end
      if (pulse && n == 1) begin
        Req = 1'b1; IsStore = 1'b1; Size = 2'b10; ByteAddr = 9'h040; StoreData = 32'h0BAD0BAD;
      end else begin
        Req = 1'b0;
      end
    end
  endtask

  initial begin
    Rst_n = 1'b0; Req = 1'b0; IsStore = 1'b0; Size = 2'b00; Unsigned = 1'b0;
    ByteAddr = 9'h0; StoreData = 32'h0; pre_we = 1'b0; pre_addr = 7'h0; pre_data = 32'h0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    check("rst_ready", {31'h0, Ready}, 32'd1);
    check("rst_done", {31'h0, Done}, 32'd0);
    check("rst_err", {31'h0, Err}, 32'd0);
    check("rst_loaddata", LoadData, 32'h0);
    check("rst_memread", {31'h0, MemRead}, 32'd0);
    check("rst_memwrite", {31'h0, MemWrite}, 32'd0);
    check("rst_wdata", MemWriteData, 32'h0);

    preload(7'd5, 32'h8899AABB);
    preload(7'd16, 32'hDEADBEEF);

    do_req(1'b0, 2'b00, 1'b0, 9'h015, 32'h0, 1'b0);
    check("lb_data", LoadData, 32'hFFFFFFAA);
    check("lb_done_cyc", done_cyc, 32'd3);
    check("lb_rd_cyc", rd_cyc, 32'd1);
    check("lb_err", {31'h0, err_seen}, 32'd0);
    check("lb_nwr", n_wr, 32'd0);

    do_req(1'b0, 2'b00, 1'b1, 9'h015, 32'h0, 1'b0);
    check("lbu_data", LoadData, 32'h000000AA);

    do_req(1'b0, 2'b01, 1'b0, 9'h016, 32'h0, 1'b0);
    check("lh_data", LoadData, 32'hFFFF8899);

    do_req(1'b0, 2'b10, 1'b0, 9'h014, 32'h0, 1'b0);
    check("lw_data", LoadData, 32'h8899AABB);
    check("lw_done_cyc", done_cyc, 32'd3);

    do_req(1'b0, 2'b01, 1'b0, 9'h015, 32'h0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    exp_ld = 32'h8899AABB;
    check("mis_done_cyc", done_cyc, 32'd1);
    check("mis_err", {31'h0, err_seen}, 32'd1);
    check("mis_nrd", n_rd, 32'd0);
    check("mis_data", LoadData, exp_ld);
`else
    exp_ld = 32'hFFFFAABB;
    check("mis_data", LoadData, exp_ld);
    check("mis_rd_cyc", rd_cyc, 32'd1);
    check("mis_err", {31'h0, err_seen}, 32'd0);
`endif

    do_req(1'b1, 2'b01, 1'b0, 9'h016, 32'h00001234, 1'b0);
    check("sh_nwr", n_wr, 32'd1);
    check("sh_wdata", wr_data, 32'h1234AABB);
    check("sh_waddr", {25'h0, wr_addr}, 32'd5);
    check("sh_wr_cyc", wr_cyc, 32'd3);
    check("sh_done_cyc", done_cyc, 32'd4);
    check("sh_mem5", mem[5], 32'h1234AABB);
    check("sh_loaddata_kept", LoadData, exp_ld);

    do_req(1'b1, 2'b00, 1'b0, 9'h014, 32'hFFFFFF77, 1'b1);
    check("sb_mem5", mem[5], 32'h1234AA77);
    check("sb_ndone", n_done, 32'd1);
    check("sb_nwr", n_wr, 32'd1);
    check("sb_nrd", n_rd, 32'd1);
    check("busy_mem16", mem[16], 32'hDEADBEEF);

    do_req(1'b1, 2'b10, 1'b0, 9'h020, 32'hCAFEF00D, 1'b0);
    check("sw_wr_cyc", wr_cyc, 32'd1);
    check("sw_done_cyc", done_cyc, 32'd2);
    check("sw_nrd", n_rd, 32'd0);
    check("sw_mem8", mem[8], 32'hCAFEF00D);

    do_req(1'b0, 2'b11, 1'b0, 9'h014, 32'h0, 1'b0);
    check("ill_done_cyc", done_cyc, 32'd1);
    check("ill_err", {31'h0, err_seen}, 32'd1);
    check("ill_nmem", n_rd + n_wr, 32'd0);
    check("ill_loaddata_kept", LoadData, exp_ld);

    // SB cut off by reset while in CAP
    @(negedge Clk);
    Req = 1'b1; IsStore = 1'b1; Size = 2'b00; ByteAddr = 9'h014; StoreData = 32'h55;
    @(posedge Clk);
    #1 Req = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    check("rstmid_memwrite", {31'h0, MemWrite}, 32'd0);
    check("rstmid_ready", {31'h0, Ready}, 32'd1);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1 check("rstmid_ready_rel", {31'h0, Ready}, 32'd1);
    wr_evts = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge Clk);
      if (MemWrite) wr_evts++;
    end
    check("rstmid_nwr", wr_evts, 32'd0);
    check("rstmid_mem5", mem[5], 32'h1234AA77);
    check("rstmid_loaddata", LoadData, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
